// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial add/subtract unit.
package serial_adder_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;
  localparam int unsigned MIN_WIDTH     = 2;
  localparam int unsigned MAX_WIDTH     = 32;

  // Sequencer states; the encoding is shared with other ALU blocks.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit counter width: must hold the value WIDTH without wrapping.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w) + 1;
  endfunction

endpackage : serial_adder_pkg

// File: rtl/serial_adder_fa2.sv
// One-bit full adder used as the serial bit cell.
module serial_adder_fa2 (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s_c,
  output logic co_c
);

  // Sum and majority carry of the three input bits.
  always_comb begin
    s_c  = a ^ b ^ cin;
    co_c = (a & b) | (a & cin) | (b & cin);
  end

endmodule : serial_adder_fa2

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one result bit per clock, LSB first.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t             state_q, state_nxt;
  logic [WIDTH-1:0]   a_sh_q, a_sh_nxt;
  logic [WIDTH-1:0]   b_sh_q, b_sh_nxt;
  logic [WIDTH-1:0]   sum_nxt;
  logic [CNT_W-1:0]   cnt_q, cnt_nxt;
  logic               carry_q, carry_nxt;
  logic               sub_q, sub_nxt;
  logic               cout_nxt, ovf_nxt;
  logic               busy_nxt, done_nxt;
  logic               armed_q;
  logic               fa_s_c, fa_co_c;

  // Serial bit cell: subtraction inverts B and seeds the carry with 1.
  serial_adder_fa2 u_fa (
    .a   (a_sh_q[0]),
    .b   (b_sh_q[0] ^ sub_q),
    .cin (carry_q),
    .s_c (fa_s_c),
    .co_c(fa_co_c)
  );

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_nxt = state_q;
    a_sh_nxt  = a_sh_q;
    b_sh_nxt  = b_sh_q;
    sum_nxt   = sum;
    cnt_nxt   = cnt_q;
    carry_nxt = carry_q;
    sub_nxt   = sub_q;
    cout_nxt  = cout;
    ovf_nxt   = ovf;

    unique case (state_q)
      IDLE: begin
        // armed_q keeps a start coincident with reset release from being taken.
        if (start && armed_q) begin
          state_nxt = RUN;
          a_sh_nxt  = a;
          b_sh_nxt  = b;
          carry_nxt = sub;
          sub_nxt   = sub;
          cnt_nxt   = '0;
          sum_nxt   = '0;
          cout_nxt  = 1'b0;
          ovf_nxt   = 1'b0;
        end
      end
      RUN: begin
        sum_nxt   = {fa_s_c, sum[WIDTH-1:1]};
        a_sh_nxt  = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_nxt  = {1'b0, b_sh_q[WIDTH-1:1]};
        carry_nxt = fa_co_c;
        cnt_nxt   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          state_nxt = DONE;
          cout_nxt  = fa_co_c;
          // Overflow: carry into the MSB differs from carry out of it.
          ovf_nxt   = carry_q ^ fa_co_c;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    busy_nxt = (state_nxt == RUN);
    done_nxt = (state_nxt == DONE);
  end

  // All state and output flops, asynchronously cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      sub_q   <= 1'b0;
      armed_q <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      state_q <= state_nxt;
      a_sh_q  <= a_sh_nxt;
      b_sh_q  <= b_sh_nxt;
      cnt_q   <= cnt_nxt;
      carry_q <= carry_nxt;
      sub_q   <= sub_nxt;
      armed_q <= 1'b1;
      busy    <= busy_nxt;
      done    <= done_nxt;
      sum     <= sum_nxt;
      cout    <= cout_nxt;
      ovf     <= ovf_nxt;
    end
  end

endmodule : serial_adder
